// File: rtl/nn_dense_layer_if.sv
// Streaming pixel input, weight-ROM port and classifier result bundle for nn_dense_layer.
interface nn_dense_layer_if #(
  parameter int N_IN  = 784,
  parameter int N_OUT = 10,
  parameter int IN_W  = 8,
  parameter int W_W   = 8,
  parameter int ACC_W = 24,
  parameter int OUT_W = 8
) ();
  localparam int AW = (N_IN > 1) ? $clog2(N_IN) : 1;

  logic                     start;
  logic                     in_valid;
  logic [IN_W-1:0]          in_data;
  logic                     in_ready;
  logic                     w_rd_en;
  logic [AW-1:0]            w_addr;
  logic [N_OUT*W_W-1:0]     w_data;
  logic [N_OUT*ACC_W-1:0]   bias;
  logic [N_OUT*OUT_W-1:0]   out_data;
  logic                     out_valid;
  logic [7:0]               digit_out;
  logic                     NN_done;
  logic                     busy;

  modport master (
    output start, in_valid, in_data, w_data, bias,
    input  in_ready, w_rd_en, w_addr, out_data, out_valid, digit_out, NN_done, busy
  );

  modport slave (
    input  start, in_valid, in_data, w_data, bias,
    output in_ready, w_rd_en, w_addr, out_data, out_valid, digit_out, NN_done, busy
  );
endinterface

// File: rtl/nn_dense_layer.sv
// Fully-connected layer: streamed MAC over N_IN elements into N_OUT parallel accumulators,
// bias add, ReLU/shift/saturate requantisation and a sequential argmax classifier.
module nn_dense_layer #(
  parameter int N_IN  = 784,
  parameter int N_OUT = 10,
  parameter int IN_W  = 8,
  parameter int W_W   = 8,
  parameter int ACC_W = 24,
  parameter int OUT_W = 8,
  parameter int SHIFT = 7,
  parameter int RELU  = 1
) (
  input logic              clk,
  input logic              reset,
  nn_dense_layer_if.slave  bus
);
  localparam int AW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int KW = $clog2(N_OUT);
  localparam int PW = IN_W + W_W;
  localparam logic [AW-1:0] LAST_IDX = AW'(N_IN - 1);
  localparam logic [AW-1:0] IDX_ONE  = AW'(1'b1);
  localparam logic [KW-1:0] K_LAST   = KW'(N_OUT - 1);
  localparam logic [KW-1:0] K_ONE    = KW'(1'b1);
  localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    DRAIN  = 3'd2,
    POST   = 3'd3,
    ARGMAX = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t                   state_r, state_s;
  logic [AW-1:0]            idx_r;
  logic signed [IN_W-1:0]   pixel_r;
  logic                     mac_pending_r;
  logic signed [ACC_W-1:0]  acc_r [N_OUT];
  logic signed [ACC_W-1:0]  sum_r [N_OUT];
  logic signed [PW-1:0]     prod_s [N_OUT];
  logic signed [ACC_W-1:0]  sum_s [N_OUT];
  logic [KW-1:0]            k_r;
  logic signed [ACC_W-1:0]  best_r, cand_s, next_best_s;
  logic [KW-1:0]            best_idx_r, next_idx_s;
  logic [N_OUT*OUT_W-1:0]   out_data_r;
  logic                     out_valid_r;
  logic [7:0]               digit_r;
  logic                     done_r;
  logic                     accept_s;
  logic                     start_s;
  logic                     last_k_s;

  // Shift (floor), optional ReLU, then clamp into the signed OUT_W range.
  function automatic logic [OUT_W-1:0] requant(input logic signed [ACC_W-1:0] s);
    logic signed [ACC_W-1:0] sh;
    sh = s >>> SHIFT;
    if ((RELU != 0) && sh[ACC_W-1]) begin
      sh = {ACC_W{1'b0}};
    end else begin
      sh = sh;
    end
    if (sh > OUT_MAX) begin
      requant = OUT_MAX[OUT_W-1:0];
    end else if (sh < OUT_MIN) begin
      requant = OUT_MIN[OUT_W-1:0];
    end else begin
      requant = sh[OUT_W-1:0];
    end
  endfunction

  assign accept_s = (state_r == LOAD) && bus.in_valid;
  assign start_s  = (state_r == IDLE) && bus.start;
  assign last_k_s = (k_r == K_LAST);

  assign bus.in_ready  = (state_r == LOAD);
  assign bus.w_rd_en   = accept_s;
  assign bus.w_addr    = idx_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_valid = out_valid_r;
  assign bus.digit_out = digit_r;
  assign bus.NN_done   = done_r;
  assign bus.busy      = (state_r != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; a start outside IDLE is simply not looked at.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) state_s = LOAD;
        else           state_s = IDLE;
      end
      LOAD: begin
        if (accept_s && (idx_r == LAST_IDX)) state_s = DRAIN;
        else                                 state_s = LOAD;
      end
      DRAIN:  state_s = POST;
      POST:   state_s = ARGMAX;
      ARGMAX: begin
        if (last_k_s) state_s = DONE;
        else          state_s = ARGMAX;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Per-neuron full-precision product and biased sum.
  always_comb begin
    for (int j = 0; j < N_OUT; j++) begin
      prod_s[j] = pixel_r * $signed(bus.w_data[j*W_W +: W_W]);
      sum_s[j]  = acc_r[j] + $signed(bus.bias[j*ACC_W +: ACC_W]);
    end
  end

  // Running argmax candidate; the first element always seeds the search.
  always_comb begin
    cand_s = sum_r[k_r];
    if ((k_r == {KW{1'b0}}) || (cand_s > best_r)) begin
      next_best_s = cand_s;
      next_idx_s  = k_r;
    end else begin
      next_best_s = best_r;
      next_idx_s  = best_idx_r;
    end
  end

  // Input capture and MAC: the weight row arrives one cycle after the accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_r         <= {AW{1'b0}};
      pixel_r       <= {IN_W{1'b0}};
      mac_pending_r <= 1'b0;
      for (int j = 0; j < N_OUT; j++) acc_r[j] <= {ACC_W{1'b0}};
    end else if (start_s) begin
      idx_r         <= {AW{1'b0}};
      mac_pending_r <= 1'b0;
      for (int j = 0; j < N_OUT; j++) acc_r[j] <= {ACC_W{1'b0}};
    end else begin
      if (accept_s) begin
        pixel_r <= bus.in_data;
        idx_r   <= idx_r + IDX_ONE;
      end
      mac_pending_r <= accept_s;
      if (mac_pending_r) begin
        for (int j = 0; j < N_OUT; j++) acc_r[j] <= acc_r[j] + ACC_W'(prod_s[j]);
      end
    end
  end

  // Bias/requantise, argmax sweep and held result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < N_OUT; j++) sum_r[j] <= {ACC_W{1'b0}};
      out_data_r  <= {(N_OUT*OUT_W){1'b0}};
      out_valid_r <= 1'b0;
      digit_r     <= 8'd0;
      done_r      <= 1'b0;
      k_r         <= {KW{1'b0}};
      best_r      <= {ACC_W{1'b0}};
      best_idx_r  <= {KW{1'b0}};
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start) out_valid_r <= 1'b0;
        end
        POST: begin
          for (int j = 0; j < N_OUT; j++) begin
            sum_r[j]                      <= sum_s[j];
            out_data_r[j*OUT_W +: OUT_W] <= requant(sum_s[j]);
          end
          k_r <= {KW{1'b0}};
        end
        ARGMAX: begin
          best_r     <= next_best_s;
          best_idx_r <= next_idx_s;
          k_r        <= k_r + K_ONE;
          if (last_k_s) begin
            digit_r     <= 8'(next_idx_s);
            out_valid_r <= 1'b1;
            done_r      <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end
endmodule
